reg_rename_file: RTL and testbench
==================================

Name: reg_rename_file

Overview:
- Architectural register file x0..x31 with a per-register rename tag (producing RoB id) and a busy bit.
- Sits between the Decoder and the RoB, and is the receiving end of the RoB's issue and commit interfaces.
- Answers the Decoder's combinational source-operand queries, returning either a value or a RoB dependency tag.
- Resolves in-flight values through the RoB's get_rob_id/get_value lookup and through same-cycle commit bypass.

Parameters:
ROB_SIZE_WIDTH, 4, RoB index width (16 entries)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
rdy  in  1  global enable; state holds when 0
clear  in  1  RoB flush (mispredict); drops all rename tags
issue_rd  in  5  destination of instruction issued this cycle; 0 = no rename
issue_rob_id  in  ROB_SIZE_WIDTH  RoB entry allocated to that instruction
commit_rd  in  5  destination of RoB head committing this cycle; 0 = no commit
commit_rob_id  in  ROB_SIZE_WIDTH  RoB id of committing entry
commit_value  in  32  committed result
rs1  in  5  Decoder source 1 index
rs2  in  5  Decoder source 2 index
val1  out  32  source 1 value (valid when has_dep1=0)
val2  out  32  source 2 value
has_dep1  out  1  source 1 still pending in RoB
has_dep2  out  1  source 2 pending
dep1  out  ROB_SIZE_WIDTH  RoB id source 1 waits on
dep2  out  ROB_SIZE_WIDTH  RoB id source 2 waits on
get_rob_id1  out  ROB_SIZE_WIDTH  RoB lookup index = tag[rs1]
get_rob_id2  out  ROB_SIZE_WIDTH  RoB lookup index = tag[rs2]
get_ready1  in  1  RoB entry get_rob_id1 has its value
get_ready2  in  1  same for get_rob_id2
get_value1  in  32  value of entry get_rob_id1
get_value2  in  32  value of entry get_rob_id2

Behaviour:
- State:
  - regs[0:31] (32b), tag[0:31] (ROB_SIZE_WIDTH), busy[0:31].
  - All state changes only on posedge clk with rst=1 and rdy=1.
- Reset (rst=0 at posedge): all regs, tags and busy cleared to 0. Reset overrides rdy, clear, issue and commit.
- Commit (commit_rd!=0):
  - regs[commit_rd] <= commit_value.
  - busy[commit_rd] <= 0 only if busy and tag[commit_rd]==commit_rob_id; a newer renamer keeps the register busy.
  - Commit is applied even when clear=1 in the same cycle.
- Issue (issue_rd!=0, clear=0):
  - busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_id.
  - If issue and commit hit the same rd, issue wins for busy/tag; the commit value is still written to regs.
- Clear: all busy <= 0; tags untouched; issue ignored that cycle.
- x0: never written, never busy; a query of x0 returns val=0, has_dep=0.
- Query (combinational, per source i; sees pre-edge state, so an instruction never depends on its own rd):
  1. rs==0 -> val=0, has_dep=0.
  2. else if !busy[rs] -> val=regs[rs], has_dep=0.
  3. else if commit_rd==rs and commit_rob_id==tag[rs] -> val=commit_value, has_dep=0.
  4. else if get_ready_i -> val=get_value_i, has_dep=0.
  5. else val=0, has_dep=1, dep=tag[rs].
- dep_i always drives tag[rs_i]; get_rob_id_i always drives tag[rs_i].
- The query is independent of rdy and clear; the Decoder gates its own issue on those.
- No latency beyond one edge: a value committed at edge N is readable from regs from cycle N+1; a rename issued at edge N is visible as has_dep from cycle N+1.

Test Plan:
- Reset: hold rst=0 two cycles, release; query rs1=5, rs2=0 -> val1=0, val2=0, has_dep1=has_dep2=0.
- Rename then commit:
  - Stimulus: issue rd=3 rob=7; next cycle query rs1=3 with get_ready1=0.
  - Expect: has_dep1=1, dep1=7, get_rob_id1=7.
  - Then commit rd=3 rob=7 value=0xDEADBEEF: same cycle val1=0xDEADBEEF, has_dep1=0; after the edge, busy[3]=0 and regs[3]=0xDEADBEEF.
- RoB forward: x4 busy with tag 2; drive get_ready1=1, get_value1=0x1234, query rs1=4 -> val1=0x1234, has_dep1=0.
- Stale commit:
  - Stimulus: issue rd=6 rob=1, then issue rd=6 rob=2, then commit rd=6 rob=1 value=9.
  - Expect: regs[6]=9, query rs1=6 -> has_dep1=1, dep1=2.
- Same-cycle issue+commit on rd=8:
  - Stimulus: tag 4 busy; commit rob=4 value=0x55 plus issue rd=8 rob=5.
  - Expect after the edge: busy[8]=1, tag=5, regs[8]=0x55.
- Clear and x0:
  - Stimulus: x10 busy; assert clear with commit rd=11 value=0xAA and issue rd=12 rob=3.
  - Expect: x10 and x12 not busy, regs[11]=0xAA.
  - Then issue rd=0 and commit rd=0 value=0xFF -> query rs1=0 returns 0 with has_dep1=0.
  - rdy=0 with issue rd=1 -> x1 stays not busy.

Source files
------------

// File: rtl/reg_rename_file_if.sv
// ---------------------------------------------------------------------------
// reg_rename_file_if
// Bundle of the issue, commit, Decoder query and RoB lookup signals that the
// rename register file exchanges with its neighbours.
//   master : Decoder/RoB side (drives issue, commit, rs and RoB lookup data)
//   slave  : register file side (returns operand values, deps, RoB lookups)
// ---------------------------------------------------------------------------
interface reg_rename_file_if #(
  parameter int ROB_SIZE_WIDTH = 4
);
  logic [4:0]                issue_rd;
  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id;
  logic [4:0]                commit_rd;
  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id;
  logic [31:0]               commit_value;
  logic [4:0]                rs1;
  logic [4:0]                rs2;
  logic [31:0]               val1;
  logic [31:0]               val2;
  logic                      has_dep1;
  logic                      has_dep2;
  logic [ROB_SIZE_WIDTH-1:0] dep1;
  logic [ROB_SIZE_WIDTH-1:0] dep2;
  logic [ROB_SIZE_WIDTH-1:0] get_rob_id1;
  logic [ROB_SIZE_WIDTH-1:0] get_rob_id2;
  logic                      get_ready1;
  logic                      get_ready2;
  logic [31:0]               get_value1;
  logic [31:0]               get_value2;

  modport master (
    output issue_rd, issue_rob_id, commit_rd, commit_rob_id, commit_value,
           rs1, rs2, get_ready1, get_ready2, get_value1, get_value2,
    input  val1, val2, has_dep1, has_dep2, dep1, dep2,
           get_rob_id1, get_rob_id2
  );

  modport slave (
    input  issue_rd, issue_rob_id, commit_rd, commit_rob_id, commit_value,
           rs1, rs2, get_ready1, get_ready2, get_value1, get_value2,
    output val1, val2, has_dep1, has_dep2, dep1, dep2,
           get_rob_id1, get_rob_id2
  );
endinterface

// File: rtl/reg_rename_file.sv
// ---------------------------------------------------------------------------
// reg_rename_file
// Architectural register file x0..x31 with a rename tag (producing RoB id)
// and busy bit per register. Answers Decoder operand queries
// combinationally, resolving in-flight values via same-cycle commit bypass
// or the RoB lookup port.
// Ports:
//   clk   : clock
//   rst   : synchronous reset, active-low
//   rdy   : global enable; state holds when 0
//   clear : RoB flush, drops all busy bits (tags retained)
//   bus   : issue/commit/query/RoB-lookup signals (slave modport)
// ---------------------------------------------------------------------------
module reg_rename_file #(
  parameter int ROB_SIZE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   clear,
  reg_rename_file_if.slave       bus
);

  localparam int W = ROB_SIZE_WIDTH;

  logic [31:0] r_regs [0:31];
  logic [W-1:0] r_tag [0:31];
  logic [31:0] r_busy;

  logic [32:0] w_res1;
  logic [32:0] w_res2;

  // Operand resolution priority; returns {has_dep, value}.
  function automatic logic [32:0] resolve(
    input logic [4:0]   rs,
    input logic         busy,
    input logic [W-1:0] tag,
    input logic [31:0]  regval,
    input logic [4:0]   c_rd,
    input logic [W-1:0] c_id,
    input logic [31:0]  c_val,
    input logic         g_rdy,
    input logic [31:0]  g_val
  );
    logic [32:0] res;
    if (rs == 5'd0) begin
      res = {1'b0, 32'h0000_0000};
    end else if (!busy) begin
      res = {1'b0, regval};
    end else if ((c_rd == rs) && (c_id == tag)) begin
      res = {1'b0, c_val};
    end else if (g_rdy) begin
      res = {1'b0, g_val};
    end else begin
      res = {1'b1, 32'h0000_0000};
    end
    return res;
  endfunction

  // State update: reset, then commit, then clear/issue (issue overrides the
  // commit's busy release on the same rd because its assignment comes later).
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'h0000_0000;
        r_tag[i]  <= '0;
      end
      r_busy <= 32'h0000_0000;
    end else if (rdy) begin
      if (bus.commit_rd != 5'd0) begin
        r_regs[bus.commit_rd] <= bus.commit_value;
        // Only the matching renamer releases the register.
        if (r_busy[bus.commit_rd] && (r_tag[bus.commit_rd] == bus.commit_rob_id)) begin
          r_busy[bus.commit_rd] <= 1'b0;
        end
      end
      if (clear) begin
        r_busy <= 32'h0000_0000;
      end else if (bus.issue_rd != 5'd0) begin
        r_busy[bus.issue_rd] <= 1'b1;
        r_tag[bus.issue_rd]  <= bus.issue_rob_id;
      end
    end
  end

  // Combinational operand queries against pre-edge state.
  always_comb begin
    w_res1 = resolve(bus.rs1, r_busy[bus.rs1], r_tag[bus.rs1], r_regs[bus.rs1],
                     bus.commit_rd, bus.commit_rob_id, bus.commit_value,
                     bus.get_ready1, bus.get_value1);
    w_res2 = resolve(bus.rs2, r_busy[bus.rs2], r_tag[bus.rs2], r_regs[bus.rs2],
                     bus.commit_rd, bus.commit_rob_id, bus.commit_value,
                     bus.get_ready2, bus.get_value2);
  end

  assign bus.val1        = w_res1[31:0];
  assign bus.has_dep1    = w_res1[32];
  assign bus.val2        = w_res2[31:0];
  assign bus.has_dep2    = w_res2[32];
  assign bus.dep1        = r_tag[bus.rs1];
  assign bus.dep2        = r_tag[bus.rs2];
  assign bus.get_rob_id1 = r_tag[bus.rs1];
  assign bus.get_rob_id2 = r_tag[bus.rs2];

endmodule

// File: tb/tb_reg_rename_file.sv
// ---------------------------------------------------------------------------
// tb_reg_rename_file
// Directed-vector bench for reg_rename_file with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_reg_rename_file;

  logic clk;
  logic rst;
  logic rdy;
  logic clear;
  int   n_cmp;
  int   n_bad;

  reg_rename_file_if #(.ROB_SIZE_WIDTH(4)) bus ();

  reg_rename_file #(.ROB_SIZE_WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.issue_rd      = 5'd0;
    bus.issue_rob_id  = 4'd0;
    bus.commit_rd     = 5'd0;
    bus.commit_rob_id = 4'd0;
    bus.commit_value  = 32'h0;
    bus.get_ready1    = 1'b0;
    bus.get_ready2    = 1'b0;
    bus.get_value1    = 32'h0;
    bus.get_value2    = 32'h0;
    clear             = 1'b0;
  endtask

  // Advance one edge; inputs settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    rdy = 1'b1;
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
    idle();
    #1;
    step();
    step();
    rst = 1'b1;

    // Reset state
    bus.rs1 = 5'd5; bus.rs2 = 5'd0; #1;
    check_eq("rst_val1", bus.val1, 32'h0);
    check_eq("rst_val2", bus.val2, 32'h0);
    check_eq("rst_dep1", {31'h0, bus.has_dep1}, 32'h0);
    check_eq("rst_dep2", {31'h0, bus.has_dep2}, 32'h0);

    // Rename x3 -> rob 7, then commit
    bus.issue_rd = 5'd3; bus.issue_rob_id = 4'd7;
    step(); idle();
    bus.rs1 = 5'd3; #1;
    check_eq("ren_hasdep", {31'h0, bus.has_dep1}, 32'h1);
    check_eq("ren_dep1", {28'h0, bus.dep1}, 32'h7);
    check_eq("ren_getid1", {28'h0, bus.get_rob_id1}, 32'h7);
    check_eq("ren_val1", bus.val1, 32'h0);
    bus.commit_rd = 5'd3; bus.commit_rob_id = 4'd7; bus.commit_value = 32'hDEADBEEF; #1;
    check_eq("byp_val1", bus.val1, 32'hDEADBEEF);
    check_eq("byp_hasdep", {31'h0, bus.has_dep1}, 32'h0);
    step(); idle();
    bus.rs2 = 5'd3; #1;
    check_eq("cmt_val1", bus.val1, 32'hDEADBEEF);
    check_eq("cmt_hasdep", {31'h0, bus.has_dep1}, 32'h0);
    check_eq("cmt_val2", bus.val2, 32'hDEADBEEF);

    // RoB forward on x4 (tag 2), both sources
    bus.issue_rd = 5'd4; bus.issue_rob_id = 4'd2;
    step(); idle();
    bus.rs1 = 5'd4; bus.rs2 = 5'd4; #1;
    check_eq("fwd_pending", {31'h0, bus.has_dep1}, 32'h1);
    bus.get_ready1 = 1'b1; bus.get_value1 = 32'h1234;
    bus.get_ready2 = 1'b1; bus.get_value2 = 32'h5678; #1;
    check_eq("fwd_val1", bus.val1, 32'h1234);
    check_eq("fwd_hasdep1", {31'h0, bus.has_dep1}, 32'h0);
    check_eq("fwd_val2", bus.val2, 32'h5678);
    check_eq("fwd_getid2", {28'h0, bus.get_rob_id2}, 32'h2);
    idle();

    // Stale commit on x6
    bus.issue_rd = 5'd6; bus.issue_rob_id = 4'd1; step();
    bus.issue_rob_id = 4'd2; step(); idle();
    bus.commit_rd = 5'd6; bus.commit_rob_id = 4'd1; bus.commit_value = 32'd9;
    step(); idle();
    bus.rs1 = 5'd6; #1;
    check_eq("stale_hasdep", {31'h0, bus.has_dep1}, 32'h1);
    check_eq("stale_dep1", {28'h0, bus.dep1}, 32'h2);
    clear = 1'b1; step(); idle(); #1;
    check_eq("stale_reg6", bus.val1, 32'd9);
    check_eq("clr_keeptag", {28'h0, bus.dep1}, 32'h2);

    // Same-cycle issue+commit on x8
    bus.issue_rd = 5'd8; bus.issue_rob_id = 4'd4; step(); idle();
    bus.commit_rd = 5'd8; bus.commit_rob_id = 4'd4; bus.commit_value = 32'h55;
    bus.issue_rd = 5'd8; bus.issue_rob_id = 4'd5;
    step(); idle();
    bus.rs1 = 5'd8; #1;
    check_eq("same_hasdep", {31'h0, bus.has_dep1}, 32'h1);
    check_eq("same_tag", {28'h0, bus.dep1}, 32'h5);
    clear = 1'b1; step(); idle(); #1;
    check_eq("same_reg8", bus.val1, 32'h55);

    // Clear with concurrent commit and issue
    bus.issue_rd = 5'd10; bus.issue_rob_id = 4'd9; step(); idle();
    clear = 1'b1;
    bus.commit_rd = 5'd11; bus.commit_rob_id = 4'd0; bus.commit_value = 32'hAA;
    bus.issue_rd = 5'd12; bus.issue_rob_id = 4'd3;
    step(); idle();
    bus.rs1 = 5'd10; bus.rs2 = 5'd12; #1;
    check_eq("clr_x10", {31'h0, bus.has_dep1}, 32'h0);
    check_eq("clr_x12", {31'h0, bus.has_dep2}, 32'h0);
    check_eq("clr_tag12", {28'h0, bus.dep2}, 32'h0);
    bus.rs1 = 5'd11; #1;
    check_eq("clr_reg11", bus.val1, 32'hAA);

    // x0 never written or renamed
    bus.issue_rd = 5'd0; bus.issue_rob_id = 4'd1;
    bus.commit_rd = 5'd0; bus.commit_value = 32'hFF;
    bus.rs1 = 5'd0; #1;
    check_eq("x0_byp", bus.val1, 32'h0);
    step(); idle(); #1;
    check_eq("x0_val", bus.val1, 32'h0);
    check_eq("x0_hasdep", {31'h0, bus.has_dep1}, 32'h0);

    // rdy=0 freezes state
    rdy = 1'b0;
    bus.issue_rd = 5'd1; bus.issue_rob_id = 4'd5;
    step(); idle(); rdy = 1'b1;
    bus.rs1 = 5'd1; #1;
    check_eq("rdy_hasdep", {31'h0, bus.has_dep1}, 32'h0);
    check_eq("rdy_tag", {28'h0, bus.dep1}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
